// File: rtl/aux_pkg.sv
// -----------------------------------------------------------------------------
// aux_pkg
// Shared definitions for the auxiliary bus. The bus reaches the hardware
// registers (E000xxxx) and the instruction RAM (FFFFxxxx).
// The request struct is shared by the arbiter, the aux decoder and the CPU aux
// port, so all three agree on field order and widths.
// -----------------------------------------------------------------------------
package aux_pkg;

  // Width of the {source, tag} field that peripherals echo back as rtag.
  localparam int AUX_TAG_W = 9;

  // Source identifiers. This value is carried in tag bit 8.
  localparam logic SRC_CPU = 1'b0;
  localparam logic SRC_DBG = 1'b1;

  // Width of the per-master outstanding-read counter.
  localparam int CNT_W = 4;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [7:0]  tag;
  } aux_req_t;

  // Value placed on aux_wdata for a forwarded request.
  // A read carries {source, tag} in the low bits. The decoder echoes these
  // bits back as rtag, which lets the response find its issuing master.
  function automatic logic [31:0] fwd_wdata(aux_req_t r, logic src);
    return r.write ? r.wdata : {{(32 - AUX_TAG_W){1'b0}}, src, r.tag};
  endfunction

endpackage

// File: rtl/aux_credit_counter.sv
// -----------------------------------------------------------------------------
// aux_credit_counter
// Counts the reads one master has in flight on the aux bus.
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   inc        in   a read from this master was accepted this cycle
//   dec_rsp    in   a response for this master returned this cycle
//   dec_abort  in   an accepted read from this master was aborted
//   cnt        out  reads currently outstanding
//   full       out  cnt == MAX_OUTSTANDING; new reads must wait
// All three events may coincide. The net change is applied in a single step
// and the result floors at zero. Responses still in flight across a reset
// therefore cannot wrap the counter.
// -----------------------------------------------------------------------------
module aux_credit_counter
  import aux_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec_rsp,
  input  logic             dec_abort,
  output logic [CNT_W-1:0] cnt,
  output logic             full
);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  int               net;

  always_comb begin
    // NOTE: every variable written here gets a value before any branch, so no path can infer a latch.
    net   = int'(cnt_q) + int'(inc) - int'(dec_rsp) - int'(dec_abort);
    cnt_d = (net < 0) ? '0 : CNT_W'(net);
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments here let every flop sample pre-edge values regardless of statement order.
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign full = (cnt_q == CNT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/aux_arbiter.sv
// -----------------------------------------------------------------------------
// aux_arbiter
// Shares the aux bus between two masters: the CPU load/store unit (master 0)
// and the debug/loader port (master 1). The arbiter sits in front of the aux
// address decoder.
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   mN_request/write/addr/
//     wstrb/wdata/tag            request from master N, held until mN_ready
//   mN_abort                     cancels master N's request accepted last cycle
//   mN_ready                     combinational accept, at most one per cycle
//   mN_rvalid/rdata/rtag         registered read response routed to master N
//   aux_request/write/addr/
//     wstrb/wdata                registered request towards the decoder
//   aux_abort                    abort for the request presented last cycle
//   aux_rvalid/rdata/rtag        response from the decoder, rtag = {src, tag}
//
// Arbitration is round-robin. The pointer flips to the other master after
// every grant, so the masters alternate strictly when both keep requesting.
// Reads are throttled by a per-master credit counter. Writes are never
// throttled.
// -----------------------------------------------------------------------------
module aux_arbiter
  import aux_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                 clock,
  input  logic                 reset,

  input  logic                 m0_request,
  input  logic                 m0_write,
  input  logic [31:0]          m0_addr,
  input  logic [3:0]           m0_wstrb,
  input  logic [31:0]          m0_wdata,
  input  logic [7:0]           m0_tag,
  input  logic                 m0_abort,
  output logic                 m0_ready,
  output logic                 m0_rvalid,
  output logic [31:0]          m0_rdata,
  output logic [7:0]           m0_rtag,

  input  logic                 m1_request,
  input  logic                 m1_write,
  input  logic [31:0]          m1_addr,
  input  logic [3:0]           m1_wstrb,
  input  logic [31:0]          m1_wdata,
  input  logic [7:0]           m1_tag,
  input  logic                 m1_abort,
  output logic                 m1_ready,
  output logic                 m1_rvalid,
  output logic [31:0]          m1_rdata,
  output logic [7:0]           m1_rtag,

  output logic                 aux_request,
  output logic                 aux_write,
  output logic [31:0]          aux_addr,
  output logic [3:0]           aux_wstrb,
  output logic [31:0]          aux_wdata,
  output logic                 aux_abort,
  input  logic                 aux_rvalid,
  input  logic [31:0]          aux_rdata,
  input  logic [AUX_TAG_W-1:0] aux_rtag
);

  // ---------------------------------------------------------------------------
  // Request collection and eligibility
  // ---------------------------------------------------------------------------
  aux_req_t [1:0]          req_in;
  aux_req_t                sel_req;
  logic     [1:0]          req_valid;
  logic     [1:0]          abort_in;
  logic     [1:0]          eligible;
  logic     [1:0]          grant;
  logic     [1:0]          full;
  logic     [1:0][CNT_W-1:0] cnt;
  logic                    any_grant;
  logic                    grant_src;

  always_comb begin
    req_in[SRC_CPU] = '{write: m0_write, addr: m0_addr, wstrb: m0_wstrb,
                        wdata: m0_wdata, tag: m0_tag};
    req_in[SRC_DBG] = '{write: m1_write, addr: m1_addr, wstrb: m1_wstrb,
                        wdata: m1_wdata, tag: m1_tag};
  end

  assign req_valid = {m1_request, m0_request};
  assign abort_in  = {m1_abort, m0_abort};

  // Eligibility uses the registered counter value. A response arriving in the
  // same cycle therefore frees a throttled read one cycle later, never within
  // the same cycle.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      eligible[n] = req_valid[n] && (req_in[n].write || !full[n]);
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin grant
  // ---------------------------------------------------------------------------
  logic pri_d, pri_q;

  always_comb begin
    grant = '0;
    if (!reset) begin
      if (&eligible) begin
        grant[pri_q] = 1'b1;
      end else begin
        grant = eligible;
      end
    end
  end

  assign any_grant = |grant;
  assign grant_src = grant[SRC_DBG];
  assign sel_req   = req_in[grant_src];

  assign m0_ready  = grant[SRC_CPU];
  assign m1_ready  = grant[SRC_DBG];

  // ---------------------------------------------------------------------------
  // Abort and response decode
  // ---------------------------------------------------------------------------
  logic       lg_valid_d, lg_valid_q;
  logic       lg_src_d, lg_src_q;
  logic       lg_read_d, lg_read_q;
  logic       abort_hit;
  logic [1:0] lg_onehot;
  logic [1:0] rsp_onehot;
  logic [1:0] rsp_hit;
  logic [1:0] abort_dec;

  // An abort counts only for the master granted in the previous cycle. Any
  // abort from the other master has no request to cancel and is dropped.
  assign abort_hit  = lg_valid_q && abort_in[lg_src_q];
  assign lg_onehot  = lg_src_q ? 2'b10 : 2'b01;
  assign abort_dec  = {2{abort_hit && lg_read_q}} & lg_onehot;

  assign rsp_onehot = aux_rtag[AUX_TAG_W-1] ? 2'b10 : 2'b01;
  assign rsp_hit    = {2{aux_rvalid}} & rsp_onehot;

  // ---------------------------------------------------------------------------
  // Credit counters
  // ---------------------------------------------------------------------------
  for (genvar n = 0; n < 2; n++) begin : g_cnt
    aux_credit_counter #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_cnt (
      .clock     (clock),
      .reset     (reset),
      .inc       (grant[n] && !req_in[n].write),
      .dec_rsp   (rsp_hit[n]),
      .dec_abort (abort_dec[n]),
      .cnt       (cnt[n]),
      .full      (full[n])
    );
  end

  // ---------------------------------------------------------------------------
  // Next-state logic for pointer, last-grant and output registers
  // ---------------------------------------------------------------------------
  logic        aux_request_d, aux_request_q;
  logic        aux_write_d, aux_write_q;
  logic [31:0] aux_addr_d, aux_addr_q;
  logic [3:0]  aux_wstrb_d, aux_wstrb_q;
  logic [31:0] aux_wdata_d, aux_wdata_q;
  logic        aux_abort_d, aux_abort_q;
  logic [1:0]  rvalid_d, rvalid_q;
  logic [7:0]  rtag_d, rtag_q;
  logic [31:0] rdata_d, rdata_q;

  always_comb begin
    pri_d         = pri_q;
    lg_valid_d    = any_grant;
    lg_src_d      = grant_src;
    lg_read_d     = !sel_req.write;

    // The request fields hold their last value while aux_request is low. This
    // avoids needless toggling on the wide decoder inputs.
    aux_request_d = any_grant;
    aux_write_d   = aux_write_q;
    aux_addr_d    = aux_addr_q;
    aux_wstrb_d   = aux_wstrb_q;
    aux_wdata_d   = aux_wdata_q;
    if (any_grant) begin
      pri_d       = ~grant_src;
      aux_write_d = sel_req.write;
      aux_addr_d  = sel_req.addr;
      aux_wstrb_d = sel_req.wstrb;
      aux_wdata_d = fwd_wdata(sel_req, grant_src);
    end

    aux_abort_d   = abort_hit;

    // Both masters see the same response data and tag. Only rvalid is
    // steered, by the source bit.
    rvalid_d      = rsp_hit;
    rtag_d        = aux_rtag[7:0];
    rdata_d       = aux_rdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pri_q         <= 1'b0;
      lg_valid_q    <= 1'b0;
      lg_src_q      <= 1'b0;
      lg_read_q     <= 1'b0;
      aux_request_q <= 1'b0;
      aux_write_q   <= 1'b0;
      // NOTE: the wide data/address registers are reset too because their zero reset value is visible at the ports.
      aux_addr_q    <= '0;
      aux_wstrb_q   <= '0;
      aux_wdata_q   <= '0;
      aux_abort_q   <= 1'b0;
      rvalid_q      <= '0;
      rtag_q        <= '0;
      rdata_q       <= '0;
    end else begin
      pri_q         <= pri_d;
      lg_valid_q    <= lg_valid_d;
      lg_src_q      <= lg_src_d;
      lg_read_q     <= lg_read_d;
      aux_request_q <= aux_request_d;
      aux_write_q   <= aux_write_d;
      aux_addr_q    <= aux_addr_d;
      aux_wstrb_q   <= aux_wstrb_d;
      aux_wdata_q   <= aux_wdata_d;
      aux_abort_q   <= aux_abort_d;
      rvalid_q      <= rvalid_d;
      rtag_q        <= rtag_d;
      rdata_q       <= rdata_d;
    end
  end

  assign aux_request = aux_request_q;
  assign aux_write   = aux_write_q;
  assign aux_addr    = aux_addr_q;
  assign aux_wstrb   = aux_wstrb_q;
  assign aux_wdata   = aux_wdata_q;
  assign aux_abort   = aux_abort_q;

  assign m0_rvalid   = rvalid_q[SRC_CPU];
  assign m1_rvalid   = rvalid_q[SRC_DBG];
  assign m0_rtag     = rtag_q;
  assign m1_rtag     = rtag_q;
  assign m0_rdata    = rdata_q;
  assign m1_rdata    = rdata_q;

endmodule

// File: tb/tb_aux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_aux_arbiter
// The bench first applies directed scenarios with literal expectations, then
// random traffic. A behavioural model checks every cycle. The model tracks
// outstanding reads as plain integers and works out grants from the
// round-robin rules.
// -----------------------------------------------------------------------------
module tb_aux_arbiter;

  localparam int MAX = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req, wr, abt, rdy, rv;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic [3:0]  wstrb [2];
  logic [7:0]  tag [2];
  logic [7:0]  rtag [2];
  logic        aux_request, aux_write, aux_abort, aux_rvalid;
  logic [31:0] aux_addr, aux_wdata, aux_rdata;
  logic [3:0]  aux_wstrb;
  logic [8:0]  aux_rtag;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clock = ~clock;

  aux_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
    .clock       (clock),
    .reset       (reset),
    .m0_request  (req[0]),
    .m0_write    (wr[0]),
    .m0_addr     (addr[0]),
    .m0_wstrb    (wstrb[0]),
    .m0_wdata    (wdata[0]),
    .m0_tag      (tag[0]),
    .m0_abort    (abt[0]),
    .m0_ready    (rdy[0]),
    .m0_rvalid   (rv[0]),
    .m0_rdata    (rdata[0]),
    .m0_rtag     (rtag[0]),
    .m1_request  (req[1]),
    .m1_write    (wr[1]),
    .m1_addr     (addr[1]),
    .m1_wstrb    (wstrb[1]),
    .m1_wdata    (wdata[1]),
    .m1_tag      (tag[1]),
    .m1_abort    (abt[1]),
    .m1_ready    (rdy[1]),
    .m1_rvalid   (rv[1]),
    .m1_rdata    (rdata[1]),
    .m1_rtag     (rtag[1]),
    .aux_request (aux_request),
    .aux_write   (aux_write),
    .aux_addr    (aux_addr),
    .aux_wstrb   (aux_wstrb),
    .aux_wdata   (aux_wdata),
    .aux_abort   (aux_abort),
    .aux_rvalid  (aux_rvalid),
    .aux_rdata   (aux_rdata),
    .aux_rtag    (aux_rtag)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model and per-cycle compare (negedge; inputs change at posedge+1)
  // ---------------------------------------------------------------------------
  int          m_cnt [2] = '{0, 0};
  int          m_pri     = 0;
  bit          m_lg_v    = 0;
  int          m_lg_s    = 0;
  bit          m_lg_r    = 0;
  logic        e_req = 0, e_wr = 0, e_abort = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_rdata = 0;
  logic [3:0]  e_wstrb = 0;
  logic [1:0]  e_rv = 0;
  logic [7:0]  e_rtag = 0;

  always @(negedge clock) begin : model
    int g;
    int net;
    bit el [2];
    bit hit;
    for (int n = 0; n < 2; n++) el[n] = req[n] && (wr[n] || m_cnt[n] < MAX);
    g = -1;
    if (!reset) begin
      if (el[0] && el[1]) g = m_pri;
      else if (el[0])     g = 0;
      else if (el[1])     g = 1;
    end
    check("m0_ready", rdy[0], g == 0);
    check("m1_ready", rdy[1], g == 1);
    check("aux_request", aux_request, e_req);
    check("aux_write", aux_write, e_wr);
    check("aux_addr", aux_addr, e_addr);
    check("aux_wstrb", aux_wstrb, e_wstrb);
    check("aux_wdata", aux_wdata, e_wdata);
    check("aux_abort", aux_abort, e_abort);
    check("m0_rvalid", rv[0], e_rv[0]);
    check("m1_rvalid", rv[1], e_rv[1]);
    check("m0_rtag", rtag[0], e_rtag);
    check("m1_rtag", rtag[1], e_rtag);
    check("m0_rdata", rdata[0], e_rdata);
    check("m1_rdata", rdata[1], e_rdata);
    check("cnt0", dut.cnt[0], m_cnt[0]);
    check("cnt1", dut.cnt[1], m_cnt[1]);

    if (reset) begin
      m_cnt = '{0, 0};
      m_pri = 0; m_lg_v = 0; m_lg_s = 0; m_lg_r = 0;
      e_req = 0; e_wr = 0; e_addr = 0; e_wstrb = 0; e_wdata = 0; e_abort = 0;
      e_rv = 0; e_rtag = 0; e_rdata = 0;
    end else begin
      hit = m_lg_v && abt[m_lg_s];
      for (int n = 0; n < 2; n++) begin
        net = m_cnt[n];
        if (g == n && !wr[n])                          net = net + 1;
        if (aux_rvalid && int'(aux_rtag[8]) == n)      net = net - 1;
        if (hit && m_lg_r && m_lg_s == n)              net = net - 1;
        m_cnt[n] = (net < 0) ? 0 : net;
      end
      e_abort = hit;
      e_req   = (g >= 0);
      m_lg_v  = (g >= 0);
      if (g >= 0) begin
        e_wr    = wr[g];
        e_addr  = addr[g];
        e_wstrb = wstrb[g];
        e_wdata = wr[g] ? wdata[g] : 32'(g * 256 + int'(tag[g]));
        m_pri   = 1 - g;
        m_lg_s  = g;
        m_lg_r  = !wr[g];
      end
      e_rv[0] = aux_rvalid && !aux_rtag[8];
      e_rv[1] = aux_rvalid &&  aux_rtag[8];
      e_rtag  = aux_rtag[7:0];
      e_rdata = aux_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    req = '0; wr = '0; abt = '0;
    for (int n = 0; n < 2; n++) begin
      addr[n] = '0; wdata[n] = '0; wstrb[n] = '0; tag[n] = '0;
    end
    aux_rvalid = 1'b0; aux_rdata = '0; aux_rtag = '0;
  endtask

  task automatic set_read(input int n, input logic [31:0] a, input logic [7:0] t);
    req[n] = 1'b1; wr[n] = 1'b0; addr[n] = a; tag[n] = t; wstrb[n] = 4'hF;
  endtask

  task automatic respond(input logic [8:0] t, input logic [31:0] d);
    aux_rvalid = 1'b1; aux_rtag = t; aux_rdata = d;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [1:0] rs;
    // Reset, with requests held high to confirm ready stays low
    reset = 1'b1;
    drive_idle();
    req = 2'b11;
    @(negedge clock);
    check("rst_m0_ready", rdy[0], 0);
    check("rst_m1_ready", rdy[1], 0);
    check("rst_aux_request", aux_request, 0);
    check("rst_aux_wdata", aux_wdata, 0);
    cyc(); cyc();
    reset = 1'b0;
    drive_idle();

    // Contention: the masters alternate, starting with m0
    for (int k = 0; k < 8; k++) begin
      cyc();
      set_read(0, 32'hE000_0000, 8'h0A);
      set_read(1, 32'hFFFF_0000, 8'h0B);
      @(negedge clock);
      check("cont_m0_ready", rdy[0], (k % 2) == 0);
      check("cont_m1_ready", rdy[1], (k % 2) == 1);
      if (k > 0) check("cont_src", aux_wdata[8], (k - 1) % 2);
    end
    cyc();
    drive_idle();
    @(negedge clock);
    check("cont_src_last", aux_wdata[8:0], 9'h10B);

    // Drain the eight reads
    for (int k = 0; k < 8; k++) begin
      cyc();
      respond((k % 2 == 0) ? 9'h00A : 9'h10B, 32'h1000 + 32'(k));
    end
    cyc();
    aux_rvalid = 1'b0;
    @(negedge clock);
    check("drain_cnt0", dut.cnt[0], 0);
    check("drain_cnt1", dut.cnt[1], 0);
    check("drain_m1_rdata", rdata[1], 32'h1007);

    // Throttle: four reads go through, the fifth is held
    for (int i = 0; i < 4; i++) begin
      cyc();
      set_read(0, 32'hE000_0004, 8'h20);
      @(negedge clock);
      check("thr_accept", rdy[0], 1);
    end
    cyc();
    @(negedge clock);
    check("thr_held", rdy[0], 0);
    cyc();
    respond(9'h012, 32'h1234_5678);
    @(negedge clock);
    check("thr_same_cycle", rdy[0], 0);
    cyc();
    aux_rvalid = 1'b0;
    @(negedge clock);
    check("thr_rvalid", rv[0], 1);
    check("thr_rtag", rtag[0], 8'h12);
    check("thr_release", rdy[0], 1);

    // Writes bypass the throttle
    cyc();
    req[0] = 1'b0;
    set_read(1, 32'hFFFF_0010, 8'h30);
    @(negedge clock);
    check("wr_setup_ready", rdy[1], 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clock);
      check("wr_setup_ready", rdy[1], 1);
    end
    cyc();
    wr[1] = 1'b1; addr[1] = 32'hE000_0010; wdata[1] = 32'hCAFE_F00D; wstrb[1] = 4'b0011;
    @(negedge clock);
    check("wr_ready", rdy[1], 1);
    check("wr_cnt_before", dut.cnt[1], 4);
    cyc();
    req[1] = 1'b0; wr[1] = 1'b0;
    @(negedge clock);
    check("wr_aux_write", aux_write, 1);
    check("wr_aux_addr", aux_addr, 32'hE000_0010);
    check("wr_aux_wdata", aux_wdata, 32'hCAFE_F00D);
    check("wr_aux_wstrb", aux_wstrb, 4'b0011);
    check("wr_cnt_after", dut.cnt[1], 4);
    for (int k = 0; k < 8; k++) begin
      cyc();
      respond((k < 4) ? 9'h020 : 9'h130, 32'(k));
    end
    cyc();
    aux_rvalid = 1'b0;
    @(negedge clock);
    check("drain2_cnt0", dut.cnt[0], 0);
    check("drain2_cnt1", dut.cnt[1], 0);

    // Abort of an m1 read; the m0_abort in the same cycle is ignored
    cyc();
    set_read(1, 32'hFFFF_0040, 8'h55);
    @(negedge clock);
    check("abt_ready", rdy[1], 1);
    cyc();
    req[1] = 1'b0; abt = 2'b11;
    @(negedge clock);
    check("abt_fwd", aux_wdata[8:0], 9'h155);
    check("abt_cnt_t1", dut.cnt[1], 1);
    cyc();
    abt = 2'b00;
    @(negedge clock);
    check("abt_aux_abort", aux_abort, 1);
    check("abt_cnt_t2", dut.cnt[1], 0);

    // m0_abort alone after an m1 grant does nothing
    cyc();
    set_read(1, 32'hFFFF_0044, 8'h55);
    cyc();
    req[1] = 1'b0; abt[0] = 1'b1;
    cyc();
    abt = 2'b00;
    @(negedge clock);
    check("abt_other_none", aux_abort, 0);
    check("abt_other_cnt", dut.cnt[1], 1);
    cyc();
    respond(9'h155, 32'h0);

    // Response routing, which is also spurious at cnt=0
    cyc();
    respond(9'h1A5, 32'hDEAD_BEEF);
    cyc();
    aux_rvalid = 1'b0;
    @(negedge clock);
    check("route_m1_rvalid", rv[1], 1);
    check("route_m1_rtag", rtag[1], 8'hA5);
    check("route_m1_rdata", rdata[1], 32'hDEAD_BEEF);
    check("route_m0_rvalid", rv[0], 0);
    check("route_cnt1_sat", dut.cnt[1], 0);

    // Reset mid-operation with cnt0=3 and pri=1
    cyc();
    set_read(0, 32'hE000_0100, 8'h33);
    cyc(); cyc();
    cyc();
    req[0] = 1'b0;
    @(negedge clock);
    check("pre_rst_cnt0", dut.cnt[0], 3);
    check("pre_rst_pri", dut.pri_q, 1);
    cyc();
    reset = 1'b1; req[0] = 1'b1;
    cyc();
    @(negedge clock);
    check("mid_rst_cnt0", dut.cnt[0], 0);
    check("mid_rst_pri", dut.pri_q, 0);
    check("mid_rst_ready", rdy[0], 0);
    check("mid_rst_aux_addr", aux_addr, 0);
    cyc();
    reset = 1'b0; req[0] = 1'b0;
    respond(9'h033, 32'hA5A5_A5A5);
    cyc();
    aux_rvalid = 1'b0;
    @(negedge clock);
    check("late_rvalid", rv[0], 1);
    check("late_rtag", rtag[0], 8'h33);
    check("late_rdata", rdata[0], 32'hA5A5_A5A5);
    check("late_cnt0", dut.cnt[0], 0);

    // Random traffic; requests are held until accepted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      rs = rdy;
      cyc();
      for (int n = 0; n < 2; n++) begin
        if (!req[n] || rs[n]) begin
          req[n]   = ($urandom_range(0, 99) < 60);
          wr[n]    = ($urandom_range(0, 99) < 30);
          addr[n]  = $urandom();
          wdata[n] = $urandom();
          wstrb[n] = 4'($urandom_range(0, 15));
          tag[n]   = 8'($urandom_range(0, 255));
        end
        abt[n] = ($urandom_range(0, 99) < 15);
      end
      aux_rvalid = ($urandom_range(0, 99) < 25);
      aux_rtag   = 9'($urandom_range(0, 511));
      aux_rdata  = $urandom();
      reset      = ($urandom_range(0, 999) < 5);
    end
    cyc();
    drive_idle();
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/aux_arbiter.md
# aux_arbiter

Two-master arbiter that shares the single auxiliary bus (hardware registers at E000xxxx, instruction RAM at FFFFxxxx) between the CPU load/store unit (master 0) and the debug/loader port (master 1). It sits directly in front of the aux address decoder. It grants at most one request per cycle using round-robin, and marks each read with its source in tag bit 8. It routes read responses back to the issuing master and limits each master's outstanding reads.

## Interface
- MAX_OUTSTANDING, 4 — maximum reads in flight per master (1..15).
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mN_request  in  1  request from master N (N = 0, 1). Held until accepted.
- mN_write  in  1  1 = write, 0 = read.
- mN_addr  in  32  byte address.
- mN_wstrb  in  4  write byte strobes.
- mN_wdata  in  32  write data. Ignored for reads.
- mN_tag  in  8  read tag.
- mN_abort  in  1  cancels this master's request accepted in the previous cycle.
- mN_ready  out  1  request accepted this cycle (combinational).
- mN_rvalid  out  1  read response valid.
- mN_rdata  out  32  read data.
- mN_rtag  out  8  tag of the response.
- aux_request  out  1  request to the decoder.
- aux_write, aux_addr[31:0], aux_wstrb[3:0], aux_wdata[31:0]  out  —  forwarded request fields.
- aux_abort  out  1  abort for the request on the decoder inputs in the previous cycle.
- aux_rvalid  in  1  response valid from the decoder.
- aux_rdata  in  32  response data.
- aux_rtag  in  9  {source, tag}.

## Operation
- **Eligibility.** Master N is eligible when mN_request=1 and (mN_write=1 or cnt[N] < MAX_OUTSTANDING). Writes are never throttled.
- **Arbitration.** Pointer `pri` (reset 0) names the preferred master.
  - Both eligible: grant `pri`.
  - One eligible: grant that master.
  - After any grant, `pri` becomes the other master.
- **Ready.** mN_ready = grant[N], at most one per cycle.
- **Forwarding.** The granted request is registered onto aux_*.
  - Read: aux_wdata = {23'b0, N, mN_tag}. The decoder and peripherals return wdata[8:0] as rtag.
  - Write: aux_wdata = mN_wdata.
  - No grant: aux_request=0.
- **Last-grant register.** Register `lg_valid`, `lg_src`, `lg_read` records the grant of the previous cycle.
- **Abort.**
  - aux_abort is registered from (lg_valid && m[lg_src]_abort). It therefore aligns with the decoder's registered request stage.
  - mN_abort while master N had no grant in the previous cycle is ignored.
- **Credit counters cnt[N]** (4 bits, reset 0):
  - +1 on an accepted read.
  - −1 on a returned response with aux_rtag[8]=N.
  - −1 on an honoured abort of a read.
  - Simultaneous +1/−1 leaves cnt[N] unchanged. Simultaneous response and abort for the same master gives −2.
  - cnt never wraps below 0 (saturate). A spurious response at cnt=0 is still forwarded.
- **Response routing.** Registered: mN_rvalid <= aux_rvalid && aux_rtag[8]==N; mN_rtag <= aux_rtag[7:0]; mN_rdata <= aux_rdata. The non-addressed master sees rvalid=0.

## Timing
- **Reset values.** All mN_rvalid, mN_rdata, mN_rtag, aux_request, aux_abort, aux_write, aux_addr, aux_wstrb, aux_wdata are 0; cnt = 0; pri = 0; lg_valid = 0. mN_ready is 0 during reset.
- **Request latency.** Accepted at cycle T → aux_request at T+1.
- **Abort timing.** mN_abort at T+1 → aux_abort at T+2, and cnt decrements at T+2.
- **Response latency.** aux_rvalid at T → mN_rvalid at T+1.
- **Throughput.** Back-to-back grants every cycle. Under constant contention the masters alternate strictly.
- **Throttle release.** A response arriving in the same cycle as a throttled read does not make that read eligible. Eligibility uses the registered cnt, so the read is accepted the next cycle.
- **Reset mid-operation.** In-flight responses arriving after reset are forwarded but do not underflow cnt.

## Structure
- **aux_pkg.**
  - AUX_TAG_W = 9, SRC_CPU = 0, SRC_DBG = 1.
  - typedef aux_req_t {write, addr, wstrb, wdata, tag}, shared with the decoder and the CPU aux port.
- **aux_credit_counter** (instantiated per master).
  - Inputs: inc, dec_rsp, dec_abort.
  - Output: cnt.
  - Output `full` = (cnt == MAX_OUTSTANDING).
- **Top level.** Arbitration, pointer, last-grant register and output registers.

## Test plan
- **Contention.** m0 and m1 both request reads every cycle for 8 cycles → grants alternate 0,1,0,1… starting with m0. aux_wdata[8] matches the source each cycle.
- **Throttle.** m0 issues 5 reads with no responses, MAX_OUTSTANDING=4 → 4 accepted, the 5th held with m0_ready=0. One response with rtag=9'h012 → m0_rvalid with m0_rtag=8'h12, and the 5th read accepted one cycle later.
- **Writes not throttled.** m1 at cnt=4 issues a write to 32'hE0000010 → accepted immediately, cnt stays 4.
- **Abort.** m1 read accepted at T, m1_abort at T+1 → aux_abort=1 at T+2, cnt[1] returns to 0. m0_abort in the same cycle produces no aux_abort.
- **Response routing.** aux_rvalid with aux_rtag=9'h1A5 and rdata=32'hDEADBEEF → m1_rvalid=1, m1_rtag=8'hA5, m1_rdata=32'hDEADBEEF, m0_rvalid=0.
- **Reset.** Assert reset with cnt[0]=3 and pri=1 → after reset cnt=0, pri=0, all outputs 0. A late response decrements nothing and is forwarded.
